// File: rtl/id_regfile_sb_pkg.sv
// Shared ID-stage types and constants for the register file and its scoreboard.
package id_regfile_sb_pkg;
    localparam int XLEN_DEF   = 32;
    localparam int PEND_W_DEF = 2;

    typedef logic [4:0]          reg_addr_t;
    typedef logic [XLEN_DEF-1:0] xlen_t;

    localparam reg_addr_t REG_ZERO = 5'd0;
endpackage

// File: rtl/id_regfile_sb_pend_counter.sv
// Saturating in-flight write counter for one register: +1 on issue, -0..2 on WB/kill.
// Reaching below zero clamps to zero and pulses underflow_o for that cycle.
module sb_pend_counter #(
    parameter int PEND_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc_i,
    input  logic [1:0]        dec_i,
    output logic [PEND_W-1:0] count_o,
    output logic              max_o,
    output logic              underflow_o
);
    localparam logic [PEND_W+1:0] MAX = {2'b00, {PEND_W{1'b1}}};

    logic [PEND_W-1:0] count_q, count_d;
    logic [PEND_W+1:0] sum, diff;
    logic              under;

    always_comb begin
        sum   = {2'b00, count_q} + {{(PEND_W+1){1'b0}}, inc_i};
        under = (sum < {{PEND_W{1'b0}}, dec_i});
        diff  = sum - {{PEND_W{1'b0}}, dec_i};
        if (under)
            count_d = '0;
        else if (diff > MAX)
            count_d = {PEND_W{1'b1}};
        else
            count_d = diff[PEND_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign count_o     = count_q;
    assign max_o       = (count_q == {PEND_W{1'b1}});
    assign underflow_o = under & ~rst;
endmodule

// File: rtl/id_regfile_sb.sv
// ID register file with write-first WB bypass and per-register pending-write scoreboard.
// Reads are combinational; stall is raised while a source/destination is still in flight.
module id_regfile_sb
    import id_regfile_sb_pkg::*;
#(
    parameter int NREG   = 32,
    parameter int XLEN   = XLEN_DEF,
    parameter int PEND_W = PEND_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            RegWrite,
    input  reg_addr_t       rd_addr,
    input  logic [XLEN-1:0] rd_data,
    input  reg_addr_t       rs1_addr,
    input  reg_addr_t       rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic            iss_valid,
    input  reg_addr_t       iss_rd,
    input  logic            kill_valid,
    input  reg_addr_t       kill_rd,
    output logic            stall,
    output logic            sb_overflow
);
    logic [XLEN-1:0]   regs_q [NREG];
    logic [PEND_W-1:0] pend [NREG];
    logic [NREG-1:0]   pend_max;
    logic [NREG-1:0]   uflow;
    logic              ovf_q, ovf_d;
    logic              wb_hit1, wb_hit2, src1_busy, src2_busy, dst_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++)
                regs_q[i] <= '0;
        end else if (RegWrite && rd_addr != REG_ZERO) begin
            regs_q[rd_addr] <= rd_data;
        end
    end

    always_comb begin
        wb_hit1 = RegWrite && (rd_addr == rs1_addr);
        wb_hit2 = RegWrite && (rd_addr == rs2_addr);
        if (rs1_addr == REG_ZERO)
            rs1_data = '0;
        else if (wb_hit1)
            rs1_data = rd_data;
        else
            rs1_data = regs_q[rs1_addr];
        if (rs2_addr == REG_ZERO)
            rs2_data = '0;
        else if (wb_hit2)
            rs2_data = rd_data;
        else
            rs2_data = regs_q[rs2_addr];
    end

    // A source completing in WB this cycle is served by the bypass, so it only
    // blocks if more writes to it remain outstanding beyond this one.
    always_comb begin
        src1_busy = pend[rs1_addr] > PEND_W'(wb_hit1);
        src2_busy = pend[rs2_addr] > PEND_W'(wb_hit2);
        dst_full  = iss_valid && pend_max[iss_rd];
        stall     = src1_busy | src2_busy | dst_full;
    end

    assign pend[0]     = '0;
    assign pend_max[0] = 1'b0;
    assign uflow[0]    = 1'b0;

    for (genvar r = 1; r < NREG; r++) begin : g_pend
        logic       inc;
        logic [1:0] dec;
        assign inc = iss_valid && !stall && (iss_rd == reg_addr_t'(r));
        assign dec = {1'b0, RegWrite && (rd_addr == reg_addr_t'(r))}
                   + {1'b0, kill_valid && (kill_rd == reg_addr_t'(r))};

        sb_pend_counter #(.PEND_W(PEND_W)) u_cnt (
            .clk         (clk),
            .rst         (rst),
            .inc_i       (inc),
            .dec_i       (dec),
            .count_o     (pend[r]),
            .max_o       (pend_max[r]),
            .underflow_o (uflow[r])
        );
    end

    always_comb begin
        ovf_d = ovf_q | (|uflow);
    end

    always_ff @(posedge clk) begin
        if (rst)
            ovf_q <= 1'b0;
        else
            ovf_q <= ovf_d;
    end

    assign sb_overflow = ovf_q;
endmodule

// File: tb/tb_id_regfile_sb.sv
// Directed scoreboard bench for id_regfile_sb: read/bypass, x0, RAW stall, saturation, kill, underflow.
module tb_id_regfile_sb;
    import id_regfile_sb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWrite;
    reg_addr_t   rd_addr;
    logic [31:0] rd_data;
    reg_addr_t   rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data;
    logic        iss_valid;
    reg_addr_t   iss_rd;
    logic        kill_valid;
    reg_addr_t   kill_rd;
    logic        stall, sb_overflow;

    always #5 clk = ~clk;

    id_regfile_sb dut (
        .clk         (clk),
        .rst         (rst),
        .RegWrite    (RegWrite),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .iss_valid   (iss_valid),
        .iss_rd      (iss_rd),
        .kill_valid  (kill_valid),
        .kill_rd     (kill_rd),
        .stall       (stall),
        .sb_overflow (sb_overflow)
    );

    typedef struct {
        string       tag;
        logic [31:0] r1;
        logic [31:0] r2;
        logic        st;
        logic        ov;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    // One cycle: drive at negedge, queue the expectation, then compare mid-cycle.
    task automatic cyc(input string tag, input logic r, input logic rw, input int rda,
                       input logic [31:0] rdd, input int a1, input int a2,
                       input logic iv, input int ird, input logic kv, input int krd,
                       input logic [31:0] e1, input logic [31:0] e2,
                       input logic es, input logic eo, input logic chk);
        exp_t e;
        @(negedge clk);
        rst = r; RegWrite = rw; rd_addr = reg_addr_t'(rda); rd_data = rdd;
        rs1_addr = reg_addr_t'(a1); rs2_addr = reg_addr_t'(a2);
        iss_valid = iv; iss_rd = reg_addr_t'(ird);
        kill_valid = kv; kill_rd = reg_addr_t'(krd);
        if (chk) begin
            e.tag = tag; e.r1 = e1; e.r2 = e2; e.st = es; e.ov = eo;
            sb_q.push_back(e);
        end
        #2;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            total++;
            assert (rs1_data === e.r1) else begin
                bad++; $error("FAIL %s rs1_data got=%h exp=%h", e.tag, rs1_data, e.r1);
            end
            total++;
            assert (rs2_data === e.r2) else begin
                bad++; $error("FAIL %s rs2_data got=%h exp=%h", e.tag, rs2_data, e.r2);
            end
            total++;
            assert (stall === e.st) else begin
                bad++; $error("FAIL %s stall got=%b exp=%b", e.tag, stall, e.st);
            end
            total++;
            assert (sb_overflow === e.ov) else begin
                bad++; $error("FAIL %s sb_overflow got=%b exp=%b", e.tag, sb_overflow, e.ov);
            end
        end
    endtask

    initial begin
        //   tag            rst rw rd data          a1 a2 iv ird kv krd  e1            e2            st ov chk
        cyc("reset",         1, 0, 0, 32'h0,        5, 0, 0, 0,  0, 0,  0,            0,            0, 0, 0);
        cyc("reset_read",    0, 0, 0, 32'h0,        5, 0, 0, 0,  0, 0,  0,            0,            0, 0, 1);
        cyc("issue3",        0, 0, 0, 32'h0,        0, 0, 1, 3,  0, 0,  0,            0,            0, 0, 1);
        cyc("wb3_bypass",    0, 1, 3, 32'hDEADBEEF, 3, 0, 0, 0,  0, 0,  32'hDEADBEEF, 0,            0, 0, 1);
        cyc("rd3_store",     0, 0, 0, 32'h0,        3, 0, 0, 0,  0, 0,  32'hDEADBEEF, 0,            0, 0, 1);
        cyc("x0_write",      0, 1, 0, 32'h1234,     0, 3, 0, 0,  0, 0,  0,            32'hDEADBEEF, 0, 0, 1);
        cyc("x0_after",      0, 0, 0, 32'h0,        0, 3, 0, 0,  0, 0,  0,            32'hDEADBEEF, 0, 0, 1);
        // RAW on x7
        cyc("issue7",        0, 0, 0, 32'h0,        0, 0, 1, 7,  0, 0,  0,            0,            0, 0, 1);
        cyc("raw7_a",        0, 0, 0, 32'h0,        0, 7, 0, 0,  0, 0,  0,            0,            1, 0, 1);
        cyc("raw7_b",        0, 0, 0, 32'h0,        0, 7, 0, 0,  0, 0,  0,            0,            1, 0, 1);
        cyc("wb7_bypass",    0, 1, 7, 32'hA5A50007, 0, 7, 0, 0,  0, 0,  0,            32'hA5A50007, 0, 0, 1);
        cyc("rd7_store",     0, 0, 0, 32'h0,        0, 7, 0, 0,  0, 0,  0,            32'hA5A50007, 0, 0, 1);
        // saturation on x9
        cyc("iss9_1",        0, 0, 0, 32'h0,        0, 0, 1, 9,  0, 0,  0,            0,            0, 0, 1);
        cyc("iss9_2",        0, 0, 0, 32'h0,        0, 0, 1, 9,  0, 0,  0,            0,            0, 0, 1);
        cyc("iss9_3",        0, 0, 0, 32'h0,        0, 0, 1, 9,  0, 0,  0,            0,            0, 0, 1);
        cyc("iss9_full",     0, 0, 0, 32'h0,        0, 0, 1, 9,  0, 0,  0,            0,            1, 0, 1);
        cyc("wb9_1",         0, 1, 9, 32'h9,        9, 0, 0, 0,  0, 0,  32'h9,        0,            1, 0, 1);
        cyc("wb9_2",         0, 1, 9, 32'h99,       9, 0, 0, 0,  0, 0,  32'h99,       0,            1, 0, 1);
        cyc("wb9_3",         0, 1, 9, 32'h999,      9, 0, 0, 0,  0, 0,  32'h999,      0,            0, 0, 1);
        cyc("rd9_idle",      0, 0, 0, 32'h0,        9, 0, 0, 0,  0, 0,  32'h999,      0,            0, 0, 1);
        // issue + writeback same rd: net change zero
        cyc("iss11",         0, 0, 0, 32'h0,        0, 0, 1, 11, 0, 0,  0,            0,            0, 0, 1);
        cyc("iss_wb11",      0, 1, 11, 32'hB,       0, 0, 1, 11, 0, 0,  0,            0,            0, 0, 1);
        cyc("pend11",        0, 0, 0, 32'h0,        11, 0, 0, 0, 0, 0,  32'hB,        0,            1, 0, 1);
        cyc("wb11_last",     0, 1, 11, 32'hBB,      11, 0, 0, 0, 0, 0,  32'hBB,       0,            0, 0, 1);
        cyc("rd11_idle",     0, 0, 0, 32'h0,        11, 0, 0, 0, 0, 0,  32'hBB,       0,            0, 0, 1);
        // WB and kill together decrement by two
        cyc("iss12_1",       0, 0, 0, 32'h0,        0, 0, 1, 12, 0, 0,  0,            0,            0, 0, 1);
        cyc("iss12_2",       0, 0, 0, 32'h0,        0, 0, 1, 12, 0, 0,  0,            0,            0, 0, 1);
        cyc("wbkill12",      0, 1, 12, 32'hC,       0, 0, 0, 0,  1, 12, 0,            0,            0, 0, 1);
        cyc("rd12_idle",     0, 0, 0, 32'h0,        12, 0, 0, 0, 0, 0,  32'hC,        0,            0, 0, 1);
        // kill then underflow on x4
        cyc("iss4",          0, 0, 0, 32'h0,        0, 0, 1, 4,  0, 0,  0,            0,            0, 0, 1);
        cyc("kill4",         0, 0, 0, 32'h0,        0, 0, 0, 0,  1, 4,  0,            0,            0, 0, 1);
        cyc("after_kill4",   0, 0, 0, 32'h0,        4, 0, 0, 0,  0, 0,  0,            0,            0, 0, 1);
        cyc("wb4_under",     0, 1, 4, 32'h44,       0, 0, 0, 0,  0, 0,  0,            0,            0, 0, 1);
        cyc("ovf_set",       0, 0, 0, 32'h0,        4, 3, 0, 0,  0, 0,  32'h44,       32'hDEADBEEF, 0, 1, 1);
        cyc("ovf_sticky",    0, 0, 0, 32'h0,        0, 0, 0, 0,  0, 0,  0,            0,            0, 1, 1);
        cyc("rst_mid",       1, 1, 5, 32'h55,       0, 0, 0, 0,  0, 0,  0,            0,            0, 1, 1);
        cyc("post_rst",      0, 0, 0, 32'h0,        3, 5, 0, 0,  0, 0,  0,            0,            0, 0, 1);
        cyc("stale_wb",      0, 1, 9, 32'h77,       0, 0, 0, 0,  0, 0,  0,            0,            0, 0, 1);
        cyc("stale_ovf",     0, 0, 0, 32'h0,        9, 0, 0, 0,  0, 0,  32'h77,       0,            0, 1, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/id_regfile_sb.md
Name: id_regfile_sb

Overview:
- Receiving end of the writeback interface. Holds the architectural register file in ID.
- Accepts one write per cycle from WB and serves two combinational read ports to ID, with a same-cycle WB-to-ID bypass.
- Tracks in-flight destination writes with a per-register pending counter (scoreboard). From that it raises a stall when an ID source or destination register is still pending.

Parameters:
- NREG, 32, number of architectural registers; x0 is hardwired to zero.
- XLEN, 32, register data width.
- PEND_W, 2, width of each pending counter; maximum in-flight writes per register is 2^PEND_W-1.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- RegWrite  in  1  WB write enable
- rd_addr  in  5  WB destination register
- rd_data  in  XLEN  WB write data
- rs1_addr  in  5  ID source 1 address
- rs2_addr  in  5  ID source 2 address
- rs1_data  out  XLEN  source 1 value, bypassed
- rs2_data  out  XLEN  source 2 value, bypassed
- iss_valid  in  1  ID issues an instruction that will write iss_rd
- iss_rd  in  5  destination of the issuing instruction
- kill_valid  in  1  an in-flight writer is squashed; its write will never reach WB
- kill_rd  in  5  destination of the squashed writer
- stall  out  1  ID must hold this cycle
- sb_overflow  out  1  sticky error flag

Behaviour:
- Reset (rst=1 at a clk edge):
  - all registers become 0
  - all pending counters become 0
  - sb_overflow becomes 0
  - rs*_data equal 0 for any address while the storage is 0
  - stall is 0 after reset
- Write: at a clk edge with RegWrite=1 and rd_addr!=0, reg[rd_addr] <= rd_data.
  - Writes to x0 are discarded.
  - A write while rst=1 is ignored; reset wins.
- Read: combinational, no latency.
  - rsN_addr==0 returns 0.
  - Otherwise, if RegWrite=1 and rd_addr==rsN_addr, the output is rd_data (write-first bypass).
  - Otherwise the output is the stored value.
- Pending counter pend[r], one per register r from 1 to NREG-1; pend[0] is always 0.
  - inc = iss_valid & ~stall & (iss_rd==r) & r!=0
  - dec = ((RegWrite & rd_addr==r) | (kill_valid & kill_rd==r)) & r!=0
  - Both the WB write and the kill may target r in the same cycle. They then count as a decrement of 2.
  - Next value is pend + inc - decrements.
  - A decrement below 0 saturates at 0 and sets sb_overflow; the flag stays set until reset.
- stall is combinational and equals 1 when any of the following holds:
  - pend[rs1_addr] minus this cycle's WB decrement for that register is nonzero;
  - the same for rs2_addr;
  - iss_valid and pend[iss_rd] == 2^PEND_W-1.
  - Consequence: a source being written back this cycle is satisfied through the bypass and does not stall.
- Stalled issue: when stall=1 the issue is not counted (no increment). ID re-presents the same instruction next cycle.
- Simultaneous issue and writeback to the same rd: the net counter change is 0. The counter is unchanged.
- Mid-operation reset: the scoreboard and the file clear in the same edge. Outstanding WB writes arriving after reset still decrement with saturation and set sb_overflow. Upstream flushes the pipe on reset, so this is an error indication only.

Decomposition:
- Shared pipeline package holds:
  - reg_addr_t (5-bit)
  - xlen_t
  - the PEND_W default
  - the REG_ZERO constant
- One natural sub-module, sb_pend_counter: a single saturating up/down counter.
  - Inputs: inc, dec count 0..2.
  - Outputs: count, max flag, underflow pulse.
  - The top instantiates NREG-1 copies in a generate loop.

Test Plan:
- Reset then read: assert rst one cycle, rs1_addr=5, rs2_addr=0 -> rs1_data=0, rs2_data=0, stall=0.
- Write then read: RegWrite=1, rd_addr=3, rd_data=0xDEADBEEF, with rs1_addr=3 in the same cycle -> rs1_data=0xDEADBEEF via bypass; next cycle, with RegWrite=0 -> 0xDEADBEEF from storage.
- x0 protection: RegWrite=1, rd_addr=0, rd_data=0x1234 -> rs1_addr=0 reads 0 in that cycle and the next.
- RAW stall: issue iss_rd=7, then ID presents rs2_addr=7 -> stall=1 for each cycle until WB writes reg 7. In the WB cycle, stall=0 and rs2_data equals rd_data.
- Counter saturation: issue iss_rd=9 three times without writeback -> pend=3. A fourth issue gives stall=1 and pend stays 3. Three WB writes to 9 bring pend to 0.
- Kill and underflow: issue iss_rd=4, then kill_rd=4 -> pend[4]=0 and sb_overflow=0. A further WB write to 4 -> sb_overflow=1, which stays 1 until rst.
